ifetch_fill_rx: RTL and testbench



---
 rtl/ifetch_fill_rx_pkg.sv | 38 +++
 rtl/ifetch_fill_rx_haming_fix32.sv | 47 ++++
 rtl/ifetch_fill_rx.sv | 149 ++++++++++++++
 tb/tb_ifetch_fill_rx.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_fill_rx_pkg.sv
// Frontend common definitions shared by the fetch-bus fill receiver and its lane decoder.
// Holds fetch-bus geometry, the fill FSM state type and the SECDED bit-placement helpers.
package ifetch_fill_rx_pkg;

  localparam int FB_LANE_W      = 39;
  localparam int FB_DATA_W      = 32;
  localparam int FB_LANES       = 8;
  localparam int FB_BEATS       = 4;
  localparam int FB_LINE_BITS   = 1024;
  localparam int FB_BEAT_DATA_W = FB_LANES * FB_DATA_W;
  localparam int FB_BUS_W       = FB_LANES * FB_LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RECV,
    ST_DONE
  } fill_state_e;

  function automatic logic is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Hamming position (1..38) of data bit b: data fills the non-power-of-two slots in order.
  function automatic int data_pos(input int b);
    int cnt;
    cnt = 0;
    for (int p = 1; p <= 38; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == b) return p;
        cnt++;
      end
    end
    return 0;
  endfunction

endpackage

// File: rtl/ifetch_fill_rx_haming_fix32.sv
// Single-lane SECDED decoder: 38-bit Hamming codeword plus overall parity in bit 38.
// Codeword bit p-1 holds Hamming position p; parity bits sit at the power-of-two positions.
module hamingFix32
  import ifetch_fill_rx_pkg::*;
(
  input  logic [FB_LANE_W-1:0] lane,
  output logic [FB_DATA_W-1:0] data,
  output logic                 corr,
  output logic                 uncorr
);

  logic [5:0] syn;
  logic       par;
  logic       do_flip;

  always_comb begin
    syn = '0;
    for (int p = 1; p <= 38; p++) begin
      if (lane[p-1]) syn = syn ^ 6'(p);
    end
  end

  assign par = ^lane;

  // A syndrome beyond the last codeword position cannot be a single error.
  assign do_flip = (syn != 6'd0) && par && (syn <= 6'd38);

  always_comb begin
    corr   = 1'b0;
    uncorr = 1'b0;
    if (syn != 6'd0) begin
      if (do_flip) corr = 1'b1;
      else         uncorr = 1'b1;
    end else if (par) begin
      corr = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FB_DATA_W; gi++) begin : g_bit
      localparam int DP = data_pos(gi);
      assign data[gi] = lane[DP-1] ^ (do_flip && (syn == 6'(DP)));
    end
  endgenerate

endmodule

// File: rtl/ifetch_fill_rx.sv
// Instruction-fetch fill receiver: takes one line miss, issues a tagged bus request and
// assembles four ECC-corrected beats into a 1024-bit line for the cache fill port.
module ifetch_fill_rx
  import ifetch_fill_rx_pkg::*;
#(
  parameter int ADDR_W  = 37,
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 64
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_en,
  input  logic [ADDR_W-1:0]       miss_addr,
  output logic                    miss_ready,
  output logic                    req_en,
  output logic [ADDR_W-1:0]       req_addr,
  output logic [7:0]              req_slot,
  input  logic                    bus_en,
  input  logic [7:0]              bus_slot,
  input  logic [FB_BUS_W-1:0]     bus_data,
  output logic                    fill_en,
  output logic [ADDR_W-1:0]       fill_addr,
  output logic [FB_LINE_BITS-1:0] fill_data,
  output logic                    fill_corr,
  output logic                    fill_uncorr,
  output logic                    fill_tmo
);

  localparam int               TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [1:0]       LAST_BEAT = 2'(BEATS - 1);
  localparam int               BUF_W     = FB_LINE_BITS - FB_BEAT_DATA_W;

  fill_state_e               state_reg;
  logic [7:0]                slot_cnt_reg;
  logic [TMO_W-1:0]          tmo_cnt_reg;
  logic [1:0]                beat_cnt_reg;
  logic [BUF_W-1:0]          line_reg;
  logic                      corr_acc_reg;
  logic                      uncorr_acc_reg;

  logic [FB_BEAT_DATA_W-1:0] beat_data;
  logic [FB_LANES-1:0]       lane_corr;
  logic [FB_LANES-1:0]       lane_uncorr;
  logic                      beat_corr;
  logic                      beat_uncorr;
  logic                      tag_hit;

  genvar gi;
  generate
    for (gi = 0; gi < FB_LANES; gi++) begin : g_lane
      hamingFix32 u_fix (
        .lane   (bus_data[gi*FB_LANE_W +: FB_LANE_W]),
        .data   (beat_data[gi*FB_DATA_W +: FB_DATA_W]),
        .corr   (lane_corr[gi]),
        .uncorr (lane_uncorr[gi])
      );
    end
  endgenerate

  assign beat_corr   = |lane_corr;
  assign beat_uncorr = |lane_uncorr;
  assign tag_hit     = bus_en && (bus_slot == req_slot);

  // Gated by rst so the block reports busy for the whole reset pulse.
  assign miss_ready = (state_reg == ST_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      slot_cnt_reg   <= '0;
      tmo_cnt_reg    <= '0;
      beat_cnt_reg   <= '0;
      line_reg       <= '0;
      corr_acc_reg   <= 1'b0;
      uncorr_acc_reg <= 1'b0;
      req_en         <= 1'b0;
      req_addr       <= '0;
      req_slot       <= '0;
      fill_en        <= 1'b0;
      fill_addr      <= '0;
      fill_data      <= '0;
      fill_corr      <= 1'b0;
      fill_uncorr    <= 1'b0;
      fill_tmo       <= 1'b0;
    end else begin
      req_en  <= 1'b0;
      fill_en <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (miss_en) begin
            req_addr  <= miss_addr;
            req_slot  <= slot_cnt_reg;
            req_en    <= 1'b1;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          slot_cnt_reg <= slot_cnt_reg + 8'd1;
          tmo_cnt_reg  <= '0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tag_hit) begin
            line_reg[FB_BEAT_DATA_W-1:0] <= beat_data;
            corr_acc_reg   <= beat_corr;
            uncorr_acc_reg <= beat_uncorr;
            beat_cnt_reg   <= 2'd1;
            state_reg      <= ST_RECV;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            fill_en     <= 1'b1;
            fill_addr   <= req_addr;
            fill_corr   <= 1'b0;
            fill_uncorr <= 1'b0;
            fill_tmo    <= 1'b1;
            state_reg   <= ST_DONE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        ST_RECV: begin
          // The responder streams beats back to back, so bus_en is not consulted here.
          if (beat_cnt_reg == LAST_BEAT) begin
            fill_en     <= 1'b1;
            fill_addr   <= req_addr;
            fill_data   <= {beat_data, line_reg};
            fill_corr   <= corr_acc_reg | beat_corr;
            fill_uncorr <= uncorr_acc_reg | beat_uncorr;
            fill_tmo    <= 1'b0;
            state_reg   <= ST_DONE;
          end else begin
            line_reg[beat_cnt_reg*FB_BEAT_DATA_W +: FB_BEAT_DATA_W] <= beat_data;
            corr_acc_reg   <= corr_acc_reg | beat_corr;
            uncorr_acc_reg <= uncorr_acc_reg | beat_uncorr;
            beat_cnt_reg   <= beat_cnt_reg + 2'd1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_fill_rx.sv
// Directed bench for ifetch_fill_rx: clean, corrected, uncorrectable, stale-tag,
// timeout, slot-wrap and mid-line reset scenarios against a local SECDED encoder.
module tb_ifetch_fill_rx;
  import ifetch_fill_rx_pkg::*;

  localparam int ADDR_W  = 37;
  localparam int TIMEOUT = 64;

  logic                    clk;
  logic                    rst;
  logic                    miss_en;
  logic [ADDR_W-1:0]       miss_addr;
  logic                    miss_ready;
  logic                    req_en;
  logic [ADDR_W-1:0]       req_addr;
  logic [7:0]              req_slot;
  logic                    bus_en;
  logic [7:0]              bus_slot;
  logic [FB_BUS_W-1:0]     bus_data;
  logic                    fill_en;
  logic [ADDR_W-1:0]       fill_addr;
  logic [FB_LINE_BITS-1:0] fill_data;
  logic                    fill_corr;
  logic                    fill_uncorr;
  logic                    fill_tmo;

  ifetch_fill_rx #(.ADDR_W(ADDR_W), .BEATS(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .miss_en(miss_en), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .req_en(req_en), .req_addr(req_addr), .req_slot(req_slot),
    .bus_en(bus_en), .bus_slot(bus_slot), .bus_data(bus_data),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_corr(fill_corr), .fill_uncorr(fill_uncorr), .fill_tmo(fill_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [38:0] cw_mem  [32];
  logic [31:0] exp_mem [32];
  logic [7:0]  exp_slot;

  // Reference encoder: data in non-power-of-two positions, even Hamming parity, overall parity on top.
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] c;
    logic        x;
    int          b;
    c = '0;
    b = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[b];
        b++;
      end
    end
    for (int m = 0; m < 6; m++) begin
      x = 1'b0;
      for (int p = 1; p <= 38; p++) if (p[m]) x = x ^ c[p-1];
      c[(1 << m) - 1] = x;
    end
    c[38] = ^c[37:0];
    return c;
  endfunction

  function automatic int dbit(input int b);
    int cnt;
    cnt = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == b) return p - 1;
        cnt++;
      end
    end
    return 0;
  endfunction

  function automatic logic [FB_LINE_BITS-1:0] exp_line();
    logic [FB_LINE_BITS-1:0] l;
    for (int i = 0; i < 32; i++) l[32*i +: 32] = exp_mem[i];
    return l;
  endfunction

  function automatic logic [FB_BUS_W-1:0] beat_bits(input int k);
    logic [FB_BUS_W-1:0] b;
    for (int j = 0; j < 8; j++) b[39*j +: 39] = cw_mem[8*k + j];
    return b;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_line(input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = base + step * 32'(i);
      cw_mem[i]  = enc(exp_mem[i]);
    end
  endtask

  // Presents a miss once the block is ready; returns at the cycle req_en is expected.
  task automatic issue_miss(input logic [ADDR_W-1:0] a, output logic ok,
                            output logic [7:0] slot, output logic [ADDR_W-1:0] ra);
    int n;
    n = 0;
    ok = 1'b0;
    slot = '0;
    ra = '0;
    while (!miss_ready && n < 20) begin
      tick();
      n++;
    end
    if (!miss_ready) return;
    miss_en = 1'b1;
    miss_addr = a;
    tick();
    miss_en = 1'b0;
    ok = req_en;
    slot = req_slot;
    ra = req_addr;
  endtask

  // Streams the four beats of cw_mem; returns at the cycle fill_en is expected.
  task automatic send_beats(input logic [7:0] tag, input int delay, output logic early);
    early = 1'b0;
    tick();
    repeat (delay) tick();
    bus_en = 1'b1;
    bus_slot = tag;
    bus_data = beat_bits(0);
    for (int k = 1; k < 4; k++) begin
      tick();
      if (k == 3) early = fill_en;
      bus_en = 1'b0;
      bus_data = beat_bits(k);
    end
    tick();
    bus_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    miss_en = 1'b0;
    miss_addr = '0;
    bus_en = 1'b0;
    bus_slot = '0;
    bus_data = '0;
    repeat (3) tick();
    checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL reset_miss_ready: got %b expected 0", miss_ready); end
    checks++; if (req_en !== 1'b0 || req_slot !== 8'h00 || req_addr !== '0) begin errors++; $display("FAIL reset_req: got en=%b slot=%h addr=%h expected 0", req_en, req_slot, req_addr); end
    checks++; if (fill_en !== 1'b0 || fill_addr !== '0 || fill_data !== '0) begin errors++; $display("FAIL reset_fill: got en=%b addr=%h expected 0", fill_en, fill_addr); end
    checks++; if ({fill_corr, fill_uncorr, fill_tmo} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {fill_corr, fill_uncorr, fill_tmo}); end
    rst = 1'b0;
    #1;
    checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", miss_ready); end
    exp_slot = 8'h00;
    $display("txn reset done");
  endtask

  task automatic test_clean();
    logic ok, early;
    logic [7:0] slot;
    logic [ADDR_W-1:0] ra;
    load_line(32'd0, 32'd1);
    issue_miss(37'h1, ok, slot, ra);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL clean_req_en: got %b expected 1", ok); end
    checks++; if (ra !== 37'h1) begin errors++; $display("FAIL clean_req_addr: got %h expected 1", ra); end
    checks++; if (slot !== exp_slot) begin errors++; $display("FAIL clean_req_slot: got %h expected %h", slot, exp_slot); end
    exp_slot++;
    send_beats(slot, 0, early);
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL clean_fill_early: got %b expected 0", early); end
    checks++; if (fill_en !== 1'b1) begin errors++; $display("FAIL clean_fill_en: got %b expected 1", fill_en); end
    checks++; if (fill_data !== exp_line()) begin errors++; $display("FAIL clean_fill_data: got %h expected %h", fill_data, exp_line()); end
    checks++; if ({fill_corr, fill_uncorr, fill_tmo} !== 3'b000) begin errors++; $display("FAIL clean_flags: got %b expected 000", {fill_corr, fill_uncorr, fill_tmo}); end
    checks++; if (fill_addr !== 37'h1) begin errors++; $display("FAIL clean_fill_addr: got %h expected 1", fill_addr); end
    tick();
    checks++; if (fill_en !== 1'b0 || miss_ready !== 1'b1) begin errors++; $display("FAIL clean_after: got fill_en=%b ready=%b expected 0/1", fill_en, miss_ready); end
    $display("txn clean addr=%h slot=%h corr=%b uncorr=%b", ra, slot, fill_corr, fill_uncorr);
  endtask

  task automatic test_single_flip();
    logic ok, early;
    logic [7:0] slot;
    logic [ADDR_W-1:0] ra;
    load_line(32'h1357_0000, 32'h0101_0101);
    cw_mem[21][dbit(17)] = ~cw_mem[21][dbit(17)];
    issue_miss(37'h0_0abc_d123, ok, slot, ra);
    checks++; if (ok !== 1'b1 || slot !== exp_slot) begin errors++; $display("FAIL flip17_req: got en=%b slot=%h expected 1/%h", ok, slot, exp_slot); end
    exp_slot++;
    send_beats(slot, 3, early);
    checks++; if (fill_en !== 1'b1) begin errors++; $display("FAIL flip17_fill_en: got %b expected 1", fill_en); end
    checks++; if (fill_data !== exp_line()) begin errors++; $display("FAIL flip17_data: got %h expected %h", fill_data, exp_line()); end
    checks++; if ({fill_corr, fill_uncorr} !== 2'b10) begin errors++; $display("FAIL flip17_flags: got %b expected 10", {fill_corr, fill_uncorr}); end
    $display("txn flip17 addr=%h slot=%h corr=%b uncorr=%b", ra, slot, fill_corr, fill_uncorr);

    load_line(32'hcafe_0000, 32'h0003_0007);
    cw_mem[10][38] = ~cw_mem[10][38];
    issue_miss(37'h0_0000_0042, ok, slot, ra);
    checks++; if (ok !== 1'b1 || slot !== exp_slot) begin errors++; $display("FAIL flip38_req: got en=%b slot=%h expected 1/%h", ok, slot, exp_slot); end
    exp_slot++;
    send_beats(slot, 1, early);
    checks++; if (fill_en !== 1'b1 || fill_data !== exp_line()) begin errors++; $display("FAIL flip38_data: got en=%b data=%h expected %h", fill_en, fill_data, exp_line()); end
    checks++; if ({fill_corr, fill_uncorr} !== 2'b10) begin errors++; $display("FAIL flip38_flags: got %b expected 10", {fill_corr, fill_uncorr}); end
    $display("txn flip38 addr=%h slot=%h corr=%b uncorr=%b", ra, slot, fill_corr, fill_uncorr);
  endtask

  task automatic test_stale_tag();
    logic ok, early;
    logic [7:0] slot;
    logic [ADDR_W-1:0] ra;
    load_line(32'h0000_0100, 32'h0000_0011);
    issue_miss(37'h1_2345_6789, ok, slot, ra);
    checks++; if (ok !== 1'b1 || slot !== 8'h03) begin errors++; $display("FAIL stale_req: got en=%b slot=%h expected 1/03", ok, slot); end
    exp_slot++;
    tick();
    bus_en = 1'b1;
    bus_slot = 8'h07;
    bus_data = beat_bits(0);
    tick();
    bus_en = 1'b0;
    bus_data = '0;
    send_beats(slot, 8, early);
    checks++; if (fill_en !== 1'b1) begin errors++; $display("FAIL stale_fill_en: got %b expected 1", fill_en); end
    checks++; if (fill_data !== exp_line() || fill_addr !== 37'h1_2345_6789) begin errors++; $display("FAIL stale_fill: got addr=%h data=%h expected %h", fill_addr, fill_data, exp_line()); end
    checks++; if ({fill_corr, fill_uncorr, fill_tmo} !== 3'b000) begin errors++; $display("FAIL stale_flags: got %b expected 000", {fill_corr, fill_uncorr, fill_tmo}); end
    $display("txn stale addr=%h slot=%h corr=%b uncorr=%b", ra, slot, fill_corr, fill_uncorr);
  endtask

  task automatic test_double_flip();
    logic ok, early;
    logic [7:0] slot;
    logic [ADDR_W-1:0] ra;
    load_line(32'h89ab_cdef, 32'h1111_1111);
    cw_mem[0][dbit(3)]  = ~cw_mem[0][dbit(3)];
    cw_mem[0][dbit(20)] = ~cw_mem[0][dbit(20)];
    exp_mem[0] = exp_mem[0] ^ 32'h0010_0008;
    issue_miss(37'h0_0000_0777, ok, slot, ra);
    checks++; if (ok !== 1'b1 || slot !== exp_slot) begin errors++; $display("FAIL double_req: got en=%b slot=%h expected 1/%h", ok, slot, exp_slot); end
    exp_slot++;
    send_beats(slot, 0, early);
    checks++; if (fill_en !== 1'b1 || fill_data !== exp_line()) begin errors++; $display("FAIL double_data: got en=%b data=%h expected %h", fill_en, fill_data, exp_line()); end
    checks++; if ({fill_corr, fill_uncorr} !== 2'b01) begin errors++; $display("FAIL double_flags: got %b expected 01", {fill_corr, fill_uncorr}); end
    $display("txn double addr=%h slot=%h corr=%b uncorr=%b", ra, slot, fill_corr, fill_uncorr);
  endtask

  task automatic test_timeout();
    logic ok;
    logic [7:0] slot;
    logic [ADDR_W-1:0] ra;
    int got;
    logic ready_at_fill;
    got = -1;
    ready_at_fill = 1'bx;
    issue_miss(37'h0_0000_5555, ok, slot, ra);
    checks++; if (ok !== 1'b1 || slot !== exp_slot) begin errors++; $display("FAIL tmo_req: got en=%b slot=%h expected 1/%h", ok, slot, exp_slot); end
    exp_slot++;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (fill_en === 1'b1) begin
        got = c;
        ready_at_fill = miss_ready;
        break;
      end
    end
    checks++; if (got != TIMEOUT + 1) begin errors++; $display("FAIL tmo_latency: got %0d expected %0d", got, TIMEOUT + 1); end
    checks++; if ({fill_corr, fill_uncorr, fill_tmo} !== 3'b001 || fill_addr !== 37'h0_0000_5555) begin errors++; $display("FAIL tmo_flags: got %b addr=%h expected 001/5555", {fill_corr, fill_uncorr, fill_tmo}, fill_addr); end
    tick();
    checks++; if (ready_at_fill !== 1'b0 || miss_ready !== 1'b1) begin errors++; $display("FAIL tmo_ready: got %b then %b expected 0 then 1", ready_at_fill, miss_ready); end
    $display("txn timeout addr=%h slot=%h tmo=%b latency=%0d", ra, slot, fill_tmo, got);
  endtask

  task automatic test_back_to_back();
    logic ok, early;
    logic [7:0] slot;
    logic [7:0] prev;
    logic [ADDR_W-1:0] ra;
    logic wrapped;
    wrapped = 1'b0;
    prev = 8'h00;
    for (int n = 0; n < 256; n++) begin
      load_line(32'(n) * 32'h0001_0001, 32'h0001_0203);
      issue_miss(37'h100 + 37'(n), ok, slot, ra);
      checks++; if (ok !== 1'b1 || slot !== exp_slot) begin errors++; $display("FAIL b2b_req %0d: got en=%b slot=%h expected 1/%h", n, ok, slot, exp_slot); end
      if (n > 0 && prev == 8'hff && slot == 8'h00) wrapped = 1'b1;
      prev = slot;
      exp_slot++;
      send_beats(slot, 0, early);
      checks++; if (fill_en !== 1'b1 || fill_data !== exp_line() || fill_addr !== ra) begin errors++; $display("FAIL b2b_fill %0d: got en=%b addr=%h expected 1/%h", n, fill_en, fill_addr, ra); end
      $display("txn b2b %0d addr=%h slot=%h", n, ra, slot);
    end
    checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL b2b_wrap: got %b expected 1", wrapped); end
  endtask

  task automatic test_reset_mid_line();
    logic ok, early;
    logic [7:0] slot;
    logic [ADDR_W-1:0] ra;
    logic seen;
    load_line(32'h4444_0000, 32'h0000_0101);
    issue_miss(37'h0_0000_0999, ok, slot, ra);
    checks++; if (ok !== 1'b1 || slot !== exp_slot) begin errors++; $display("FAIL rstmid_req: got en=%b slot=%h expected 1/%h", ok, slot, exp_slot); end
    tick();
    bus_en = 1'b1;
    bus_slot = slot;
    bus_data = beat_bits(0);
    tick();
    bus_en = 1'b0;
    bus_data = beat_bits(1);
    tick();
    bus_data = beat_bits(2);
    rst = 1'b1;
    #1;
    checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", miss_ready); end
    tick();
    rst = 1'b0;
    bus_data = beat_bits(3);
    #1;
    checks++; if (req_slot !== 8'h00 || fill_data !== '0 || fill_addr !== '0 || miss_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state: got slot=%h addr=%h ready=%b expected 00/0/1", req_slot, fill_addr, miss_ready); end
    seen = 1'b0;
    repeat (8) begin
      tick();
      bus_data = '0;
      if (fill_en === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_fill: got %b expected 0", seen); end
    $display("txn reset_mid addr=%h slot=%h", ra, slot);

    exp_slot = 8'h00;
    load_line(32'h0000_0000, 32'h0000_0001);
    issue_miss(37'h0_0000_0001, ok, slot, ra);
    checks++; if (ok !== 1'b1 || slot !== 8'h00) begin errors++; $display("FAIL post_rst_req: got en=%b slot=%h expected 1/00", ok, slot); end
    exp_slot++;
    send_beats(slot, 2, early);
    checks++; if (fill_en !== 1'b1 || fill_data !== exp_line()) begin errors++; $display("FAIL post_rst_fill: got en=%b data=%h expected %h", fill_en, fill_data, exp_line()); end
    checks++; if ({fill_corr, fill_uncorr, fill_tmo} !== 3'b000) begin errors++; $display("FAIL post_rst_flags: got %b expected 000", {fill_corr, fill_uncorr, fill_tmo}); end
    $display("txn post_reset addr=%h slot=%h corr=%b uncorr=%b", ra, slot, fill_corr, fill_uncorr);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_flip();
    test_stale_tag();
    test_double_flip();
    test_timeout();
    test_back_to_back();
    test_reset_mid_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
